seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for N_DIGITS seven-segment digits sharing one segment bus; successor to the three-output combinational BCD decoder in the timer display path.
- Latches a packed BCD word atomically at frame boundaries, scans one digit at a time with a programmable dwell, and applies per-digit blanking and output polarity.
- Sits between the timer counters and the board display pins.

---
 rtl/seg7_scan_driver.sv | 125 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver with frame-atomic digit capture.
// Optional leading-zero suppression is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int N_DIGITS   = 3,
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     blank,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0]       COUNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]       IDX_MAX   = IW'(N_DIGITS - 1);
    // XOR masks double as the dark/reset levels of the pins.
    localparam logic [6:0]          SEG_OFF   = {7{ACTIVE_LOW != 0}};
    localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{ACTIVE_LOW != 0}};

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 7'b1111110;
            4'd1:    encode = 7'b0110000;
            4'd2:    encode = 7'b1101101;
            4'd3:    encode = 7'b1111001;
            4'd4:    encode = 7'b0110011;
            4'd5:    encode = 7'b1011011;
            4'd6:    encode = 7'b1011111;
            4'd7:    encode = 7'b1110000;
            4'd8:    encode = 7'b1111111;
            4'd9:    encode = 7'b1110011;
            default: encode = 7'b0000001;
        endcase
    endfunction

    logic [CW-1:0]           count_reg;
    logic [IW-1:0]           idx_reg;
    logic [4*N_DIGITS-1:0]   pend_reg;
    logic                    pend_v_reg;
    logic [4*N_DIGITS-1:0]   disp_reg;
    logic [6:0]              seg_reg;
    logic [N_DIGITS-1:0]     an_reg;
    logic                    frame_done_reg;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              digit_arr [N_DIGITS];
    logic [N_DIGITS-1:0]     suppress;
    logic                    hide;
    logic [6:0]              seg_next;
    logic [N_DIGITS-1:0]     an_next;

    assign tick = (count_reg == COUNT_MAX);
    assign wrap = tick && (idx_reg == IDX_MAX);

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign digit_arr[gi] = disp_reg[4*gi +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            // A digit goes dark when it and everything to its left are zero.
            if (gi == 0) begin : g_lsd
                assign suppress[gi] = 1'b0;
            end else begin : g_upper
                assign suppress[gi] = ~|disp_reg[4*N_DIGITS-1:4*gi];
            end
`else
            assign suppress[gi] = 1'b0;
`endif
        end
    endgenerate

    always_comb begin
        hide     = blank[idx_reg] | suppress[idx_reg];
        seg_next = 7'b0000000;
        an_next  = '0;
        if (!hide) begin
            seg_next = encode(digit_arr[idx_reg]);
            an_next  = N_DIGITS'(1) << idx_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg      <= '0;
            idx_reg        <= '0;
            pend_reg       <= '0;
            pend_v_reg     <= 1'b0;
            disp_reg       <= '0;
            seg_reg        <= SEG_OFF;
            an_reg         <= AN_OFF;
            frame_done_reg <= 1'b0;
        end else begin
            count_reg <= tick ? '0 : count_reg + 1'b1;
            if (tick) begin
                idx_reg <= (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
            end
            // A load on the wrap cycle bypasses pend so it lands in this frame.
            if (wrap) begin
                pend_v_reg <= 1'b0;
                if (load) begin
                    disp_reg <= digits_in;
                end else if (pend_v_reg) begin
                    disp_reg <= pend_reg;
                end
            end else if (load) begin
                pend_reg   <= digits_in;
                pend_v_reg <= 1'b1;
            end
            frame_done_reg <= wrap;
            seg_reg        <= seg_next ^ SEG_OFF;
            an_reg         <= an_next ^ AN_OFF;
        end
    end

    assign seg        = seg_reg;
    assign an         = an_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: active-high and active-low instances side by side.
module tb_seg7_scan_driver;

    localparam int N     = 3;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;
    localparam int NV    = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [11:0]   digits_in = '0;
    logic          load = 1'b0;
    logic [2:0]    blank = '0;
    logic [6:0]    seg, seg_lo;
    logic [2:0]    an, an_lo;
    logic          fd, fd_lo;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(DIV), .ACTIVE_LOW(0)) dut_hi (
        .clk(clk), .reset(reset), .digits_in(digits_in), .load(load), .blank(blank),
        .seg(seg), .an(an), .frame_done(fd)
    );

    seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(DIV), .ACTIVE_LOW(1)) dut_lo (
        .clk(clk), .reset(reset), .digits_in(digits_in), .load(load), .blank(blank),
        .seg(seg_lo), .an(an_lo), .frame_done(fd_lo)
    );

    typedef struct {
        logic             two;
        logic [11:0]      pre;
        logic [11:0]      val;
        logic [2:0]       blk;
        logic [2:0][6:0]  s;
        logic [2:0][2:0]  a;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic two, input logic [11:0] pre, input logic [11:0] val,
                                input logic [2:0] blk,
                                input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0,
                                input logic [2:0] a2, input logic [2:0] a1, input logic [2:0] a0);
        vec_t r;
        r.two = two;
        r.pre = pre;
        r.val = val;
        r.blk = blk;
        r.s   = {s2, s1, s0};
        r.a   = {a2, a1, a0};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic to_frame_start();
        while (cyc % FRAME != 0) step();
    endtask

    task automatic check_slot(input string name, input logic [6:0] es, input logic [2:0] ea);
        logic [6:0] ies;
        logic [2:0] iea;
        ies = ~es;
        iea = ~ea;
        chk({name, "_seg"}, seg, es);
        chk({name, "_an"}, an, ea);
        chk({name, "_seg_lo"}, seg_lo, ies);
        chk({name, "_an_lo"}, an_lo, iea);
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_seg"}, seg, 7'b0000000);
        chk({name, "_an"}, an, 3'b000);
        chk({name, "_fd"}, fd, 1'b0);
        chk({name, "_seg_lo"}, seg_lo, 7'b1111111);
        chk({name, "_an_lo"}, an_lo, 3'b111);
        chk({name, "_fd_lo"}, fd_lo, 1'b0);
    endtask

    initial begin
        vecs[0] = mk(1'b0, 12'h000, 12'h159, 3'b000,
                     7'b0110000, 7'b1011011, 7'b1110011, 3'b100, 3'b010, 3'b001);
        vecs[1] = mk(1'b1, 12'h159, 12'h2A4, 3'b000,
                     7'b1101101, 7'b0000001, 7'b0110011, 3'b100, 3'b010, 3'b001);
        vecs[2] = mk(1'b0, 12'h000, 12'h888, 3'b010,
                     7'b1111111, 7'b0000000, 7'b1111111, 3'b100, 3'b000, 3'b001);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        vecs[3] = mk(1'b0, 12'h000, 12'h037, 3'b000,
                     7'b0000000, 7'b1111001, 7'b1110000, 3'b000, 3'b010, 3'b001);
        vecs[4] = mk(1'b0, 12'h000, 12'h005, 3'b000,
                     7'b0000000, 7'b0000000, 7'b1011011, 3'b000, 3'b000, 3'b001);
`else
        vecs[3] = mk(1'b0, 12'h000, 12'h037, 3'b000,
                     7'b1111110, 7'b1111001, 7'b1110000, 3'b100, 3'b010, 3'b001);
        vecs[4] = mk(1'b0, 12'h000, 12'h005, 3'b000,
                     7'b1111110, 7'b1111110, 7'b1011011, 3'b100, 3'b010, 3'b001);
`endif
        vecs[5] = mk(1'b0, 12'h000, 12'hF60, 3'b100,
                     7'b0000000, 7'b1011111, 7'b1111110, 3'b000, 3'b010, 3'b001);

        // Reset state, then first frame with a load at cycle 2.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        cyc = 0;
        step();
        step();
        digits_in = 12'h159;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        check_slot("first_d0", 7'b1111110, 3'b001);
        while (cyc < 11) step();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check_slot("first_d2", 7'b0000000, 3'b000);
`else
        check_slot("first_d2", 7'b1111110, 3'b100);
`endif
        chk("first_fd_low", fd, 1'b0);
        step();
        chk("first_fd_pulse", fd, 1'b1);
        chk("first_fd_pulse_lo", fd_lo, 1'b1);
        step();
        chk("first_fd_cleared", fd, 1'b0);
        check_slot("frame2_d0", 7'b1110011, 3'b001);
        $display("seq first_frame: load 159 at cycle 2, shown after wrap at cycle 12");
        to_frame_start();

        // Table: load during one frame, check every cycle of the following frame.
        for (int v = 0; v < NV; v++) begin
            blank = 3'b000;
            digits_in = vecs[v].two ? vecs[v].pre : vecs[v].val;
            load = 1'b1;
            step();
            load = 1'b0;
            if (vecs[v].two) begin
                step();
                step();
                digits_in = vecs[v].val;
                load = 1'b1;
                step();
                load = 1'b0;
            end
            to_frame_start();
            chk($sformatf("v%0d_fd", v), fd, 1'b1);
            blank = vecs[v].blk;
            for (int d = 0; d < N; d++) begin
                for (int k = 0; k < DIV; k++) begin
                    step();
                    check_slot($sformatf("v%0d_d%0d_k%0d", v, d, k), vecs[v].s[d], vecs[v].a[d]);
                    if (d == 1 && k == 0) chk($sformatf("v%0d_fd_mid", v), fd, 1'b0);
                end
            end
            $display("vector %0d: disp=%h blank=%b two_loads=%0d", v, vecs[v].val, vecs[v].blk, vecs[v].two);
        end
        blank = 3'b000;

        // Load on the wrap cycle itself overrides an earlier pending load.
        digits_in = 12'h999;
        load = 1'b1;
        step();
        load = 1'b0;
        while (cyc % FRAME != FRAME - 1) step();
        digits_in = 12'h321;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("wrapload_fd", fd, 1'b1);
        step();
        check_slot("wrapload_d0", 7'b0110000, 3'b001);
        for (int k = 0; k < DIV; k++) step();
        check_slot("wrapload_d1", 7'b1101101, 3'b010);
        for (int k = 0; k < DIV; k++) step();
        check_slot("wrapload_d2", 7'b1111001, 3'b100);
        $display("seq wrap_load: 999 pending, 321 on wrap cycle, 321 shown");
        to_frame_start();

        // Reset mid-frame with a pending load: immediate reset, load discarded.
        digits_in = 12'h777;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        while (cyc < FRAME) step();
        chk("post_reset_fd", fd, 1'b1);
        step();
        check_slot("post_reset_d0", 7'b1111110, 3'b001);
        for (int k = 0; k < DIV; k++) step();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check_slot("post_reset_d1", 7'b0000000, 3'b000);
`else
        check_slot("post_reset_d1", 7'b1111110, 3'b010);
`endif
        $display("seq reset_mid_frame: pending 777 discarded, display zero");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
